// File: rtl/pio_pulse_pkg.sv
// rtl/pio_pulse_pkg.sv - command word layout and FSM states for the PIO pulse train
package pio_pulse_pkg;

  localparam int GO_BIT    = 15;
  localparam int ABORT_BIT = 14;
  localparam int N_MSB     = 13;
  localparam int N_LSB     = 8;
  localparam int H_MSB     = 7;
  localparam int H_LSB     = 4;
  localparam int L_MSB     = 3;
  localparam int L_LSB     = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pio_tick_gen.sv
// rtl/pio_tick_gen.sv - free-running prescaler producing one tick every PRESCALE clocks
module pio_tick_gen #(
  parameter int PRESCALE = 50,
  parameter int PW       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + PW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/pio_pulse_train.sv
// rtl/pio_pulse_train.sv - burst pulse generator driven by a toggle-started PIO command word
module pio_pulse_train
  import pio_pulse_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int PW       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cmd_word,
  output logic        pulse_out,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [5:0]  pulses_left
);

  state_t     state;
  logic       go_prev;
  logic [3:0] h_len;
  logic [3:0] l_len;
  logic [3:0] phase;
  // one bit wider than the port so a 64-pulse burst is representable
  logic [6:0] remaining;
  logic       tick;
  logic       go_evt;
  logic       abort;
  logic       accept;
  logic       phase_end;

  assign go_evt    = cmd_word[GO_BIT] ^ go_prev;
  assign abort     = cmd_word[ABORT_BIT];
  assign accept    = (state == IDLE) && go_evt && !abort;
  assign phase_end = tick && (phase == ((state == HIGH) ? h_len : l_len));

  pio_tick_gen #(
    .PRESCALE (PRESCALE),
    .PW       (PW)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    go_prev <= cmd_word[GO_BIT];
    if (reset) begin
      state     <= IDLE;
      pulse_out <= 1'b0;
      overrun   <= 1'b0;
      remaining <= '0;
      phase     <= '0;
      h_len     <= '0;
      l_len     <= '0;
    end else if (abort) begin
      state     <= IDLE;
      pulse_out <= 1'b0;
      remaining <= '0;
      phase     <= '0;
    end else begin
      if (go_evt && state != IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (go_evt) begin
            h_len     <= cmd_word[H_MSB:H_LSB];
            l_len     <= cmd_word[L_MSB:L_LSB];
            remaining <= 7'(cmd_word[N_MSB:N_LSB]) + 7'd1;
            phase     <= '0;
            pulse_out <= 1'b1;
            overrun   <= 1'b0;
            state     <= HIGH;
          end
        end
        HIGH: begin
          if (phase_end) begin
            phase     <= '0;
            pulse_out <= 1'b0;
            state     <= LOW;
          end else if (tick) begin
            phase <= phase + 4'd1;
          end
        end
        LOW: begin
          if (phase_end) begin
            phase <= '0;
            if (remaining == 7'd1) begin
              remaining <= '0;
              state     <= IDLE;
            end else begin
              remaining <= remaining - 7'd1;
              pulse_out <= 1'b1;
              state     <= HIGH;
            end
          end else if (tick) begin
            phase <= phase + 4'd1;
          end
        end
        default: begin
          pulse_out <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // done marks the last LOW cycle itself, so it lines up with the final busy clock
  assign done        = (state == LOW) && phase_end && (remaining == 7'd1) && !abort;
  assign busy        = (state != IDLE);
  assign pulses_left = remaining[5:0];

endmodule

// File: tb/tb_pio_pulse_train.sv
// tb/tb_pio_pulse_train.sv - scoreboard bench for pio_pulse_train with PRESCALE=2
module tb_pio_pulse_train;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cmd_word = 16'h8000;
  logic        pulse_out;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [5:0]  pulses_left;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int n;
    int hi;
    int lo;
    int total;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  pio_pulse_train #(
    .PRESCALE (2),
    .PW       (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_word    (cmd_word),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .pulses_left (pulses_left)
  );

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // monitor: measures each burst and compares against the queued expectation on done
  int   m_np = 0;
  int   m_hi = 0;
  int   m_lo = 0;
  int   m_busy = 0;
  logic m_pp = 1'b0;
  logic m_pb = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (busy && !m_pb) begin
        m_np = 0; m_hi = 0; m_lo = 0; m_busy = 0;
      end
      if (busy) begin
        m_busy++;
        if (pulse_out) begin
          if (!m_pp) begin
            if (m_np > 0 && exp_q.size() > 0) check("mon_low_width", m_lo, exp_q[0].lo);
            m_np++;
            if (exp_q.size() > 0)
              check("mon_pulses_left", int'(pulses_left), (exp_q[0].n - m_np + 1) & 63);
            m_hi = 0;
          end
          m_hi++;
        end else begin
          if (m_pp) begin
            if (exp_q.size() > 0) check("mon_high_width", m_hi, exp_q[0].hi);
            m_lo = 0;
          end
          m_lo++;
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("mon_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("mon_done_busy", int'(busy), 1);
          check("mon_last_low_width", m_lo, e.lo);
          check("mon_pulse_count", m_np, e.n);
          check("mon_busy_clocks", m_busy, e.total);
          check("mon_pulses_left_at_done", int'(pulses_left), 1);
        end
      end
      m_pp = pulse_out;
      m_pb = busy;
    end
  end

  task automatic run_burst(input logic [13:0] fields, input int en, input int ehi, input int elo,
                           input int etot, input int poke_at, input logic [15:0] poke_mask,
                           input int exp_ovr, input string tag);
    int got;
    got = -1;
    exp_q.push_back('{en, ehi, elo, etot});
    @(posedge clk); #1;
    cmd_word = {~cmd_word[15], 1'b0, fields};
    @(negedge clk);
    check({tag, "_pre_busy"}, int'(busy), 0);
    for (int c = 1; c <= etot + 20; c++) begin
      @(posedge clk); #1;
      if (c == poke_at) cmd_word = cmd_word ^ poke_mask;
      @(negedge clk);
      if (c == 1) begin
        check({tag, "_latency_pulse"}, int'(pulse_out), 1);
        check({tag, "_overrun_cleared"}, int'(overrun), 0);
      end
      if (done) begin
        got = c;
        break;
      end
    end
    check({tag, "_done_clock"}, got, etot);
    @(negedge clk);
    check({tag, "_idle_busy"}, int'(busy), 0);
    check({tag, "_idle_pulses_left"}, int'(pulses_left), 0);
    check({tag, "_idle_done"}, int'(done), 0);
    check({tag, "_overrun"}, int'(overrun), exp_ovr);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    // reset with the go bit already high: release must not start a burst
    repeat (3) @(negedge clk);
    check("reset_pulse_out", int'(pulse_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_pulses_left", int'(pulses_left), 0);
    check("reset_overrun", int'(overrun), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_reset_quiet", int'({pulse_out, busy, overrun, done}), 0);
    end

    // N=1 H=1 L=1
    run_burst(14'h0000, 1, 2, 2, 4, 0, 16'h0000, 0, "min");
    // N=3 H=4 L=2, fields scrambled mid-burst must not matter
    run_burst(14'h0231, 3, 8, 4, 36, 5, 16'h3FFF, 0, "n3");
    // second toggle while busy is dropped and flagged
    run_burst(14'h0000, 1, 2, 2, 4, 3, 16'h8000, 1, "ovr");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_second_burst", int'(busy), 0);
    end
    // N=1 H=4 L=16, also clears the sticky overrun
    run_burst(14'h003F, 1, 8, 32, 40, 0, 16'h0000, 0, "long_low");
    // toggle in the very cycle done is asserted still counts as overrun
    run_burst(14'h0000, 1, 2, 2, 4, 4, 16'h8000, 1, "ovr_final");

    // abort mid-burst with the go bit toggled in the same write
    @(posedge clk); #1;
    cmd_word = {~cmd_word[15], 1'b0, 14'h0F11};
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 10) cmd_word = {~cmd_word[15], 1'b1, cmd_word[13:0]};
      @(negedge clk);
      if (c == 10) begin
        check("abort_pre_pulse", int'(pulse_out), 1);
        check("abort_pre_pulses_left", int'(pulses_left), 15);
      end
    end
    @(negedge clk);
    check("abort_pulse_out", int'(pulse_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_pulses_left", int'(pulses_left), 0);
    check("abort_overrun", int'(overrun), 0);
    @(posedge clk); #1;
    cmd_word[14] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_release_quiet", int'({busy, done}), 0);
    end

    // abort landing on the final LOW expiry suppresses done
    @(posedge clk); #1;
    cmd_word = {~cmd_word[15], 1'b0, 14'h0000};
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 4) cmd_word[14] = 1'b1;
      @(negedge clk);
    end
    check("abort_final_done", int'(done), 0);
    check("abort_final_busy", int'(busy), 1);
    @(negedge clk);
    check("abort_final_after_busy", int'(busy), 0);
    check("abort_final_after_done", int'(done), 0);
    // go toggle under abort in IDLE: consumed, no start, no overrun
    @(posedge clk); #1;
    cmd_word[15] = ~cmd_word[15];
    repeat (5) @(negedge clk);
    check("abort_idle_toggle_busy", int'(busy), 0);
    check("abort_idle_toggle_overrun", int'(overrun), 0);
    @(posedge clk); #1;
    cmd_word[14] = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_idle_release_busy", int'(busy), 0);

    // N=64 H=1 L=1
    run_burst(14'h3F00, 64, 2, 2, 256, 0, 16'h0000, 0, "n64");

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
